// File: rtl/mii_gen_pkg.sv
// rtl/mii_gen_pkg.sv - shared state encoding, framing constants and LFSR step for the MII frame generator
package mii_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_HDR,
        ST_PAY,
        ST_FCS,
        ST_IFG
    } state_t;

    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    // Galois taps for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS   = 32'h0040_0007;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return v[31] ? ({v[30:0], 1'b0} ^ LFSR_TAPS) : {v[30:0], 1'b0};
    endfunction

endpackage

// File: rtl/crc32_byte_next.sv
// rtl/crc32_byte_next.sv - combinational one-byte step of the reflected IEEE 802.3 CRC-32
module crc32_byte_next
    import mii_gen_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] c;

    always_comb begin
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_next = c;
    end

endmodule

// File: rtl/mii_frame_gen.sv
// rtl/mii_frame_gen.sv - Ethernet frame generator driving an MII (nibble) or GMII (byte) transmit port
module mii_frame_gen
    import mii_gen_pkg::*;
#(
    parameter int          DW      = 4,
    parameter logic [31:0] SEED    = 32'h1234_5678,
    parameter int          MIN_IFG = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [10:0]   cfg_length,
    input  logic [47:0]   cfg_da,
    input  logic [47:0]   cfg_sa,
    input  logic [15:0]   cfg_len_type,
    input  logic          cfg_mode,
    input  logic          cfg_crc_err,
    input  logic [7:0]    cfg_ifg,
    output logic [DW-1:0] tx_d,
    output logic          tx_en,
    output logic          tx_er,
    output logic          busy,
    output logic          done,
    output logic [15:0]   frame_cnt
);

    localparam logic [7:0] MIN_IFG_B = 8'(MIN_IFG);

    state_t        state;
    state_t        nxt_state;
    logic [10:0]   cnt;
    logic [10:0]   nxt_cnt;
    logic [10:0]   pay_len;
    logic          nib;
    logic [7:0]    cur_byte;
    logic [7:0]    nxt_byte;
    logic [111:0]  hdr;
    logic          mode_q;
    logic          err_q;
    logic [8:0]    gap_q;
    logic [8:0]    gap_req;
    logic [8:0]    gap_left;
    logic [7:0]    ifg_eff;
    logic [31:0]   lfsr;
    logic [31:0]   crc;
    logic [31:0]   crc_upd;
    logic [31:0]   fcs;
    logic          byte_last;

    assign tx_er     = 1'b0;
    assign byte_last = (DW == 8) || nib;
    assign fcs       = ~crc ^ {32{err_q}};
    assign ifg_eff   = (cfg_ifg > MIN_IFG_B) ? cfg_ifg : MIN_IFG_B;
    assign gap_req   = (DW == 8) ? {1'b0, ifg_eff} : {ifg_eff, 1'b0};

    // Position and value of the byte that follows the one currently on the wire
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 11'd1;
        nxt_byte  = 8'h00;
        case (state)
            ST_PRE: if (cnt == 11'd6) begin nxt_state = ST_SFD; nxt_cnt = '0; end
            ST_SFD: begin nxt_state = ST_HDR; nxt_cnt = '0; end
            ST_HDR: if (cnt == 11'd13) begin
                nxt_state = (pay_len == 11'd0) ? ST_FCS : ST_PAY;
                nxt_cnt   = '0;
            end
            ST_PAY: if (cnt == pay_len - 11'd1) begin nxt_state = ST_FCS; nxt_cnt = '0; end
            ST_FCS: if (cnt == 11'd3) begin nxt_state = ST_IFG; nxt_cnt = '0; end
            default: ;
        endcase
        case (nxt_state)
            ST_PRE:  nxt_byte = PRE_BYTE;
            ST_SFD:  nxt_byte = SFD_BYTE;
            ST_HDR:  nxt_byte = hdr[8 * (4'd13 - nxt_cnt[3:0]) +: 8];
            ST_PAY:  nxt_byte = mode_q ? nxt_cnt[7:0] : lfsr[7:0];
            ST_FCS:  nxt_byte = fcs[{nxt_cnt[1:0], 3'b000} +: 8];
            default: nxt_byte = 8'h00;
        endcase
    end

    crc32_byte_next u_crc (
        .crc      (crc),
        .data     (nxt_byte),
        .crc_next (crc_upd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            nib       <= 1'b0;
            cur_byte  <= '0;
            hdr       <= '0;
            mode_q    <= 1'b0;
            err_q     <= 1'b0;
            pay_len   <= '0;
            gap_q     <= '0;
            gap_left  <= '0;
            lfsr      <= SEED;
            crc       <= '1;
            tx_d      <= '0;
            tx_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    hdr      <= {cfg_da, cfg_sa, cfg_len_type};
                    mode_q   <= cfg_mode;
                    err_q    <= cfg_crc_err;
                    pay_len  <= (cfg_length < 11'd14) ? 11'd0 : cfg_length - 11'd14;
                    gap_q    <= gap_req;
                    crc      <= '1;
                    state    <= ST_PRE;
                    cnt      <= '0;
                    nib      <= 1'b0;
                    cur_byte <= PRE_BYTE;
                    tx_d     <= PRE_BYTE[DW-1:0];
                    tx_en    <= 1'b1;
                    busy     <= 1'b1;
                end
                // Runs one cycle short: the IDLE accept cycle that follows completes the gap
                ST_IFG: if (gap_left == 9'd0) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end else begin
                    gap_left <= gap_left - 9'd1;
                    if (gap_left == 9'd1) begin
                        done      <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                default: if (!byte_last) begin
                    nib  <= 1'b1;
                    tx_d <= cur_byte[7 -: DW];
                end else begin
                    state    <= nxt_state;
                    cnt      <= nxt_cnt;
                    nib      <= 1'b0;
                    cur_byte <= nxt_byte;
                    if (nxt_state == ST_IFG) begin
                        tx_en    <= 1'b0;
                        tx_d     <= '0;
                        gap_left <= gap_q - 9'd2;
                    end else begin
                        tx_d <= nxt_byte[DW-1:0];
                    end
                    if (nxt_state == ST_HDR || nxt_state == ST_PAY) crc <= crc_upd;
                    if (nxt_state == ST_PAY && !mode_q) lfsr <= lfsr_next(lfsr);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mii_frame_gen.sv
// tb/tb_mii_frame_gen.sv - scoreboard bench for mii_frame_gen in nibble and byte widths
module tb_mii_frame_gen;

    logic        clk = 1'b0;
    logic        r4, r8, s4, s8;
    logic [10:0] cfg_length;
    logic [47:0] cfg_da, cfg_sa;
    logic [15:0] cfg_len_type;
    logic        cfg_mode, cfg_crc_err;
    logic [7:0]  cfg_ifg;

    logic [3:0]  d4_tx_d;
    logic        d4_tx_en, d4_tx_er, d4_busy, d4_done;
    logic [15:0] d4_frame_cnt;
    logic [7:0]  d8_tx_d;
    logic        d8_tx_en, d8_tx_er, d8_busy, d8_done;
    logic [15:0] d8_frame_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]  exp4[$], exp8[$];
    int          elen4[$], elen8[$], ecyc4[$], ecyc8[$];
    bit          eerr4[$], eerr8[$];
    logic [31:0] m_lfsr4 = 32'h1234_5678;
    logic [31:0] m_lfsr8 = 32'h1234_5678;
    bit          abort8 = 1'b0;

    logic [7:0]  rx4[$], rx8[$];
    bit          prev4 = 1'b0, prev8 = 1'b0, ph4 = 1'b0;
    bit          dirty4 = 1'b0, dirty8 = 1'b0;
    int          cyc4 = 0, cyc8 = 0, low4 = 0, gap4 = 0;
    logic [3:0]  lo4 = 4'h0;

    always #5 clk = ~clk;

    mii_frame_gen #(.DW(4)) dut4 (
        .clk(clk), .reset(r4), .start(s4), .cfg_length(cfg_length), .cfg_da(cfg_da),
        .cfg_sa(cfg_sa), .cfg_len_type(cfg_len_type), .cfg_mode(cfg_mode),
        .cfg_crc_err(cfg_crc_err), .cfg_ifg(cfg_ifg), .tx_d(d4_tx_d), .tx_en(d4_tx_en),
        .tx_er(d4_tx_er), .busy(d4_busy), .done(d4_done), .frame_cnt(d4_frame_cnt)
    );

    mii_frame_gen #(.DW(8)) dut8 (
        .clk(clk), .reset(r8), .start(s8), .cfg_length(cfg_length), .cfg_da(cfg_da),
        .cfg_sa(cfg_sa), .cfg_len_type(cfg_len_type), .cfg_mode(cfg_mode),
        .cfg_crc_err(cfg_crc_err), .cfg_ifg(cfg_ifg), .tx_d(d8_tx_d), .tx_en(d8_tx_en),
        .tx_er(d8_tx_er), .busy(d8_busy), .done(d8_done), .frame_cnt(d8_frame_cnt)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    function automatic logic [31:0] ref_lfsr(input logic [31:0] v);
        logic [31:0] t;
        t = v << 1;
        if (v[31]) t = t ^ 32'h0040_0007;
        return t;
    endfunction

    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB8_8320;
            else c = c >> 1;
        end
        return c;
    endfunction

    // Expected frame (preamble through FCS) from the current cfg_* addresses
    task automatic push_frame(input bit sel, input int len, input bit mode, input bit err, input int cyc);
        logic [7:0]   f[$];
        logic [31:0]  c, lf;
        logic [111:0] h;
        int           plen;
        lf = sel ? m_lfsr8 : m_lfsr4;
        h  = {cfg_da, cfg_sa, cfg_len_type};
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        for (int i = 0; i < 14; i++) f.push_back(h[111 - 8 * i -: 8]);
        plen = (len < 14) ? 0 : len - 14;
        for (int k = 0; k < plen; k++) begin
            if (mode) f.push_back(8'(k));
            else begin f.push_back(lf[7:0]); lf = ref_lfsr(lf); end
        end
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < f.size(); i++) c = ref_crc(c, f[i]);
        c = ~c ^ {32{err}};
        for (int i = 0; i < 4; i++) f.push_back(c[8 * i +: 8]);
        if (sel) begin
            m_lfsr8 = lf;
            foreach (f[i]) exp8.push_back(f[i]);
            elen8.push_back(f.size()); ecyc8.push_back(cyc); eerr8.push_back(err);
        end else begin
            m_lfsr4 = lf;
            foreach (f[i]) exp4.push_back(f[i]);
            elen4.push_back(f.size()); ecyc4.push_back(cyc); eerr4.push_back(err);
        end
    endtask

    task automatic score_frame(input bit sel, input int cyc);
        logic [7:0]  rx[$];
        logic [7:0]  e;
        logic [31:0] r;
        int          n, ce, mism, first, tag;
        bit          err, dirty;
        tag = sel ? 8 : 4;
        if (sel && abort8) begin abort8 = 1'b0; return; end
        if (sel) begin rx = rx8; dirty = dirty8; dirty8 = 1'b0; end
        else begin rx = rx4; dirty = dirty4; dirty4 = 1'b0; end
        if ((sel ? elen8.size() : elen4.size()) == 0) begin
            check($sformatf("d%0d_unexpected_frame", tag), 1, 0);
            return;
        end
        if (sel) begin n = elen8.pop_front(); ce = ecyc8.pop_front(); err = eerr8.pop_front(); end
        else begin n = elen4.pop_front(); ce = ecyc4.pop_front(); err = eerr4.pop_front(); end
        check($sformatf("d%0d_txen_cycles", tag), cyc, ce);
        mism = 0; first = -1;
        for (int i = 0; i < n; i++) begin
            e = sel ? exp8.pop_front() : exp4.pop_front();
            if (i >= rx.size() || rx[i] !== e) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        check($sformatf("d%0d_frame_bytes(bad count, first at %0d)", tag, first), mism, 0);
        r = 32'hFFFF_FFFF;
        for (int i = 8; i < rx.size(); i++) r = ref_crc(r, rx[i]);
        if (!err) check($sformatf("d%0d_fcs_residue", tag), r, 32'hDEBB_20E3);
        else check($sformatf("d%0d_corrupt_fcs_residue_differs", tag), r != 32'hDEBB_20E3, 1);
        check($sformatf("d%0d_idle_lines_clean", tag), dirty, 0);
    endtask

    always @(negedge clk) begin
        if (d4_tx_er) dirty4 = 1'b1;
        if (d4_tx_en) begin
            if (!prev4) begin gap4 = low4; cyc4 = 0; ph4 = 1'b0; rx4.delete(); end
            cyc4++;
            if (!ph4) lo4 = d4_tx_d;
            else rx4.push_back({d4_tx_d, lo4});
            ph4 = ~ph4;
        end else begin
            if (d4_tx_d != 4'h0) dirty4 = 1'b1;
            low4 = prev4 ? 1 : low4 + 1;
            if (prev4) score_frame(1'b0, cyc4);
        end
        prev4 = d4_tx_en;
    end

    always @(negedge clk) begin
        if (d8_tx_er) dirty8 = 1'b1;
        if (d8_tx_en) begin
            if (!prev8) begin cyc8 = 0; rx8.delete(); end
            cyc8++;
            rx8.push_back(d8_tx_d);
        end else begin
            if (d8_tx_d != 8'h00) dirty8 = 1'b1;
            if (prev8) score_frame(1'b1, cyc8);
        end
        prev8 = d8_tx_en;
    end

    task automatic start_frame(input bit sel, input int len, input bit mode, input bit err,
                               input int cyc, input bit push);
        @(negedge clk);
        cfg_length  = 11'(len);
        cfg_mode    = mode;
        cfg_crc_err = err;
        if (push) push_frame(sel, len, mode, err, cyc);
        if (sel) s8 = 1'b1; else s4 = 1'b1;
        @(posedge clk); #1;
        if (sel) begin
            check("d8_accept_busy", d8_busy, 1);
            check("d8_accept_txen", d8_tx_en, 1);
            check("d8_accept_txd", d8_tx_d, 8'h55);
        end else begin
            check("d4_accept_busy", d4_busy, 1);
            check("d4_accept_txen", d4_tx_en, 1);
            check("d4_accept_txd", d4_tx_d, 4'h5);
        end
        s4 = 1'b0;
        s8 = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sel ? d8_done : d4_done) begin ok = 1'b1; break; end
        end
        if (!ok) check($sformatf("d%0d_done_timeout", sel ? 8 : 4), 0, 1);
    endtask

    initial begin
        logic [31:0] lf;
        r4 = 1'b1; r8 = 1'b1; s4 = 1'b0; s8 = 1'b0;
        cfg_length = 11'd60; cfg_da = 48'hFFFF_FFFF_FFFF; cfg_sa = 48'hE0E1_E2E3_E4E5;
        cfg_len_type = 16'h0806; cfg_mode = 1'b1; cfg_crc_err = 1'b0; cfg_ifg = 8'd0;
        repeat (3) @(negedge clk);
        check("d4_reset_txen", d4_tx_en, 0);
        check("d4_reset_txd", d4_tx_d, 0);
        check("d4_reset_txer", d4_tx_er, 0);
        check("d4_reset_busy", d4_busy, 0);
        check("d4_reset_done", d4_done, 0);
        check("d4_reset_frame_cnt", d4_frame_cnt, 0);
        check("d8_reset_txen", d8_tx_en, 0);
        r4 = 1'b0; r8 = 1'b0;

        // Broadcast ARP-style frame, incrementing payload, good and corrupted FCS
        start_frame(1'b0, 60, 1'b1, 1'b0, 144, 1'b1);
        wait_done(1'b0);
        check("d4_frame_cnt_1", d4_frame_cnt, 1);
        start_frame(1'b0, 60, 1'b1, 1'b1, 144, 1'b1);
        wait_done(1'b0);
        check("d4_frame_cnt_2", d4_frame_cnt, 2);

        // Undersized length clamps to a header-only frame
        cfg_da = 48'h0011_2233_4455; cfg_sa = 48'h6677_8899_AABB; cfg_len_type = 16'h88B5;
        start_frame(1'b0, 5, 1'b1, 1'b0, 52, 1'b1);
        wait_done(1'b0);
        check("d4_frame_cnt_3", d4_frame_cnt, 3);

        // Start held high: two back-to-back LFSR frames at the minimum gap
        cfg_length = 11'd20; cfg_mode = 1'b0; cfg_crc_err = 1'b0; cfg_ifg = 8'd0;
        push_frame(1'b0, 20, 1'b0, 1'b0, 64);
        push_frame(1'b0, 20, 1'b0, 1'b0, 64);
        @(negedge clk);
        s4 = 1'b1;
        wait_done(1'b0);
        check("b2b_frame_cnt_4", d4_frame_cnt, 4);
        @(negedge clk);
        check("b2b_busy_low_after_done", d4_busy, 0);
        check("b2b_done_single_cycle", d4_done, 0);
        @(posedge clk); #1;
        check("b2b_accept_after_done", d4_busy, 1);
        @(negedge clk);
        s4 = 1'b0;
        wait_done(1'b0);
        check("b2b_frame_cnt_5", d4_frame_cnt, 5);
        check("b2b_txen_low_gap", gap4, 24);

        // Byte-wide LFSR frame
        cfg_da = 48'h0200_0000_0001; cfg_sa = 48'h0200_0000_0002; cfg_len_type = 16'h0800;
        start_frame(1'b1, 100, 1'b0, 1'b0, 112, 1'b1);
        wait_done(1'b1);
        check("d8_frame_cnt_1", d8_frame_cnt, 1);

        // Reset lands on payload byte 30; the aborted frame is not scored
        start_frame(1'b1, 100, 1'b0, 1'b0, 0, 1'b0);
        repeat (52) @(posedge clk);
        #1;
        lf = m_lfsr8;
        repeat (30) lf = ref_lfsr(lf);
        check("d8_payload_byte_30", d8_tx_d, lf[7:0]);
        #1;
        abort8 = 1'b1;
        r8 = 1'b1;
        #1;
        check("d8_reset_drops_txen", d8_tx_en, 0);
        check("d8_reset_frame_cnt", d8_frame_cnt, 0);
        check("d8_reset_busy", d8_busy, 0);
        @(negedge clk);
        r8 = 1'b0;
        m_lfsr8 = 32'h1234_5678;
        start_frame(1'b1, 40, 1'b0, 1'b0, 52, 1'b1);
        wait_done(1'b1);
        check("d8_frame_cnt_after_reset", d8_frame_cnt, 1);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp4.size() + exp8.size() + elen4.size() + elen8.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
